// File: rtl/cpu_step_controller.sv
// cpu_step_controller
//   Single-clock enable generator and debug-step controller for the 16-bit pipelined CPU.
//   Pipeline registers run on CLK and load only when cpu_ce=1. The supported modes are free-run,
//   programmable divide, debounced single-step, and run-to-breakpoint with step-over resume.
//   The block also counts executed (enabled) cycles for the debug display.
//
// Ports
//   CLK         system clock, all state on the rising edge
//   RST         asynchronous active-low reset
//   mode        00 free-run, 01 divided, 10 single-step, 11 run-to-breakpoint
//   div_ratio   divided mode: one enable every div_ratio+1 cycles
//   button      raw active-low push button (asynchronous)
//   bp_en       breakpoint enable
//   bp_addr     breakpoint address
//   pc          current fetch-stage PC
//   cpu_ce      pipeline clock enable
//   halted      high while stopped at a breakpoint
//   btn_pulse   one-cycle debounced press event
//   step_count  number of cycles with cpu_ce=1 (wraps)
module cpu_step_controller #(
   parameter int unsigned DIV_W           = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned PC_W            = 16,
   parameter int unsigned CNT_W           = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] div_ratio,
   input  logic             button,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic [PC_W-1:0]  pc,
   output logic             cpu_ce,
   output logic             halted,
   output logic             btn_pulse,
   output logic [CNT_W-1:0] step_count
);

   localparam int unsigned DebW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      StRun,
      StHalt,
      StStepOver
   } state_e;

   // ---------------------------------------------------------------------------
   // Button synchroniser and debouncer
   // ---------------------------------------------------------------------------
   logic            sync1_q, sync2_q;
   logic            stable_q, stable_d;
   logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
   logic            btn_pulse_q, btn_pulse_d;

   always_comb begin
      stable_d  = stable_q;
      deb_cnt_d = '0;
      if (sync2_q != stable_q) begin
         // Accept the new level only after it has differed for DEBOUNCE_CYCLES cycles in a row
         if (deb_cnt_q == DebLast) begin
            stable_d = sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DebW'(1);
         end
      end
      // Press is a 1->0 transition of the debounced level; release makes no event
      btn_pulse_d = stable_q & ~stable_d;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         stable_q    <= 1'b1;
         deb_cnt_q   <= '0;
         btn_pulse_q <= 1'b0;
      end else begin
         sync1_q     <= button;
         sync2_q     <= sync1_q;
         stable_q    <= stable_d;
         deb_cnt_q   <= deb_cnt_d;
         btn_pulse_q <= btn_pulse_d;
      end
   end

   assign btn_pulse = btn_pulse_q;

   // ---------------------------------------------------------------------------
   // Enable request, divider and breakpoint state machine
   // ---------------------------------------------------------------------------
   logic              ce_req_q, ce_req_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   state_e            state_q, state_d;
   logic              halted_q, halted_d;
   logic              bp_hit;
   logic [CNT_W-1:0]  step_count_q;

   assign bp_hit = (mode == 2'b11) & bp_en & (pc == bp_addr) & (state_q == StRun);
   assign cpu_ce = ce_req_q & ~bp_hit;

   always_comb begin
      ce_req_d  = 1'b0;
      div_cnt_d = '0;
      state_d   = StRun;
      case (mode)
         2'b00: ce_req_d = 1'b1;
         2'b01: begin
            // >= so that a smaller ratio written mid-count fires immediately
            if (div_cnt_q >= div_ratio) begin
               ce_req_d = 1'b1;
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         2'b10: ce_req_d = btn_pulse_q;
         default: begin
            case (state_q)
               StRun: begin
                  // Entering HALT must not carry a stale enable into the first halted cycle,
                  // where bp_hit no longer masks it.
                  if (bp_hit) begin
                     state_d  = StHalt;
                     ce_req_d = 1'b0;
                  end else begin
                     ce_req_d = 1'b1;
                  end
               end
               StHalt: begin
                  if (btn_pulse_q) begin
                     state_d  = StStepOver;
                     ce_req_d = 1'b1;
                  end else begin
                     state_d  = StHalt;
                  end
               end
               StStepOver: begin
                  // bp_hit is masked here, so this single enable moves past bp_addr
                  state_d  = StRun;
                  ce_req_d = 1'b1;
               end
               default: begin
                  state_d  = StRun;
                  ce_req_d = 1'b0;
               end
            endcase
         end
      endcase
      halted_d = (state_d == StHalt);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ce_req_q     <= 1'b0;
         div_cnt_q    <= '0;
         state_q      <= StRun;
         halted_q     <= 1'b0;
         step_count_q <= '0;
      end else begin
         ce_req_q  <= ce_req_d;
         div_cnt_q <= div_cnt_d;
         state_q   <= state_d;
         halted_q  <= halted_d;
         if (cpu_ce) begin
            step_count_q <= step_count_q + CNT_W'(1);
         end
      end
   end

   assign halted     = halted_q;
   assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// tb_cpu_step_controller
//   Directed bench for cpu_step_controller with a short debounce window (8 cycles).
//   Inputs change on the falling clock edge and outputs are sampled there as well.
//   The bench PC advances on cpu_ce, as the fetch stage would.
module tb_cpu_step_controller;

   logic        CLK = 1'b0;
   logic        RST;
   logic [1:0]  mode;
   logic [7:0]  div_ratio;
   logic        button;
   logic        bp_en;
   logic [15:0] bp_addr;
   logic [15:0] pc;
   logic        cpu_ce;
   logic        halted;
   logic        btn_pulse;
   logic [31:0] step_count;
   logic        pc_clr;

   int          tests    = 0;
   int          failures = 0;

   int          ce_n, pulse_n, first_ce, first_pulse;
   logic [19:0] pat;
   logic [31:0] sc0;
   logic        found;

   cpu_step_controller #(
      .DIV_W           (8),
      .DEBOUNCE_CYCLES (8),
      .PC_W            (16),
      .CNT_W           (32)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .mode       (mode),
      .div_ratio  (div_ratio),
      .button     (button),
      .bp_en      (bp_en),
      .bp_addr    (bp_addr),
      .pc         (pc),
      .cpu_ce     (cpu_ce),
      .halted     (halted),
      .btn_pulse  (btn_pulse),
      .step_count (step_count)
   );

   always #5 CLK = ~CLK;

   // Fetch-stage PC stand-in
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pc <= '0;
      end else if (pc_clr) begin
         pc <= '0;
      end else if (cpu_ce) begin
         pc <= pc + 16'd1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n cycles, counting enables and press events (first index is 1-based, 0 = none)
   task automatic run(input int n, output int ce_cnt, output int p_cnt,
                      output int f_ce, output int f_p);
      ce_cnt = 0;
      p_cnt  = 0;
      f_ce   = 0;
      f_p    = 0;
      for (int i = 1; i <= n; i++) begin
         @(negedge CLK);
         if (cpu_ce) begin
            ce_cnt++;
            if (f_ce == 0) f_ce = i;
         end
         if (btn_pulse) begin
            p_cnt++;
            if (f_p == 0) f_p = i;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST       = 1'b0;
      mode      = 2'b00;
      div_ratio = 8'd0;
      button    = 1'b1;
      bp_en     = 1'b0;
      bp_addr   = 16'd0;
      pc_clr    = 1'b0;

      // Reset state
      repeat (3) @(negedge CLK);
      check("rst_cpu_ce", 32'(cpu_ce), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_step_count", step_count, 32'd0);
      check("rst_btn_pulse", 32'(btn_pulse), 32'd0);

      // Free-run: 0 in the first cycle, then 1; 10 edges give 9 counted cycles
      RST = 1'b1;
      check("free_first_cycle", 32'(cpu_ce), 32'd0);
      @(negedge CLK);
      check("free_second_cycle", 32'(cpu_ce), 32'd1);
      repeat (9) @(negedge CLK);
      check("free_step_count", step_count, 32'd9);

      // Divided by 4
      mode      = 2'b01;
      div_ratio = 8'd3;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         pat[i] = cpu_ce;
      end
      check("div4_pattern", 32'(pat), 32'h0008_8888);
      repeat (2) @(negedge CLK);
      check("div4_midcount", 32'(cpu_ce), 32'd0);
      div_ratio = 8'd0;
      run(5, ce_n, pulse_n, first_ce, first_pulse);
      check("div1_every_cycle", 32'(ce_n), 32'd5);

      // Debounce in free-run mode
      mode   = 2'b00;
      button = 1'b0;
      repeat (3) @(negedge CLK);
      button = 1'b1;
      run(30, ce_n, pulse_n, first_ce, first_pulse);
      check("glitch_no_pulse", 32'(pulse_n), 32'd0);
      button = 1'b0;
      run(20, ce_n, pulse_n, first_ce, first_pulse);
      check("press1_one_pulse", 32'(pulse_n), 32'd1);
      check("press1_latency", 32'(first_pulse), 32'd10);
      button = 1'b1;
      run(20, ce_n, pulse_n, first_ce, first_pulse);
      check("release_no_pulse", 32'(pulse_n), 32'd0);
      button = 1'b0;
      run(20, ce_n, pulse_n, first_ce, first_pulse);
      check("press2_one_pulse", 32'(pulse_n), 32'd1);
      button = 1'b1;
      run(20, ce_n, pulse_n, first_ce, first_pulse);

      // Single-step
      mode = 2'b10;
      @(negedge CLK);
      check("step_idle", 32'(cpu_ce), 32'd0);
      sc0 = step_count;
      button = 1'b0;
      run(20, ce_n, pulse_n, first_ce, first_pulse);
      check("step1_ce_count", 32'(ce_n), 32'd1);
      check("step1_pulse_at", 32'(first_pulse), 32'd10);
      check("step1_ce_at", 32'(first_ce), 32'd11);
      button = 1'b1;
      run(20, ce_n, pulse_n, first_ce, first_pulse);
      check("step_release_no_ce", 32'(ce_n), 32'd0);
      button = 1'b0;
      run(20, ce_n, pulse_n, first_ce, first_pulse);
      check("step2_ce_count", 32'(ce_n), 32'd1);
      check("step2_ce_at", 32'(first_ce), 32'd11);
      check("step_count_delta", step_count - sc0, 32'd2);
      button = 1'b1;
      run(20, ce_n, pulse_n, first_ce, first_pulse);

      // Run to breakpoint at 0x0005
      mode    = 2'b11;
      bp_en   = 1'b1;
      bp_addr = 16'h0005;
      pc_clr  = 1'b1;
      @(negedge CLK);
      pc_clr = 1'b0;
      check("bp_start_pc", 32'(pc), 32'd0);
      check("bp_start_ce", 32'(cpu_ce), 32'd1);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge CLK);
         if (pc == 16'h0005) found = 1'b1;
      end
      check("bp_reach_pc5", 32'(found), 32'd1);
      check("bp_hit_ce", 32'(cpu_ce), 32'd0);
      check("bp_hit_not_halted_yet", 32'(halted), 32'd0);
      @(negedge CLK);
      check("bp_halted", 32'(halted), 32'd1);
      check("bp_halt_ce", 32'(cpu_ce), 32'd0);
      run(100, ce_n, pulse_n, first_ce, first_pulse);
      check("bp_hold_no_ce", 32'(ce_n), 32'd0);
      check("bp_hold_pc", 32'(pc), 32'd5);
      bp_en = 1'b0;
      run(10, ce_n, pulse_n, first_ce, first_pulse);
      check("bp_en_drop_still_halted", 32'(halted), 32'd1);
      check("bp_en_drop_pc", 32'(pc), 32'd5);
      bp_en  = 1'b1;
      button = 1'b0;
      found  = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge CLK);
         if (btn_pulse) found = 1'b1;
      end
      check("resume_pulse_seen", 32'(found), 32'd1);
      check("resume_pulse_cycle_ce", 32'(cpu_ce), 32'd0);
      @(negedge CLK);
      check("stepover_ce", 32'(cpu_ce), 32'd1);
      check("stepover_halted", 32'(halted), 32'd0);
      check("stepover_pc", 32'(pc), 32'd5);
      @(negedge CLK);
      check("after_step_pc", 32'(pc), 32'd6);
      check("after_step_ce", 32'(cpu_ce), 32'd1);
      run(10, ce_n, pulse_n, first_ce, first_pulse);
      check("resume_free_run", 32'(ce_n), 32'd10);
      check("resume_pc", 32'(pc), 32'd16);
      button = 1'b1;

      // Breakpoint disabled: passes address 5 without stopping
      bp_en  = 1'b0;
      pc_clr = 1'b1;
      @(negedge CLK);
      pc_clr = 1'b0;
      check("nobp_start_pc", 32'(pc), 32'd0);
      run(20, ce_n, pulse_n, first_ce, first_pulse);
      check("nobp_ce_count", 32'(ce_n), 32'd20);
      check("nobp_pc", 32'(pc), 32'd20);
      check("nobp_halted", 32'(halted), 32'd0);

      // Asynchronous reset while halted
      bp_en  = 1'b1;
      pc_clr = 1'b1;
      @(negedge CLK);
      pc_clr = 1'b0;
      found  = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge CLK);
         if (halted) found = 1'b1;
      end
      check("rst2_halted_before", 32'(found), 32'd1);
      #2;
      RST = 1'b0;
      #1;
      check("rst2_halted", 32'(halted), 32'd0);
      check("rst2_cpu_ce", 32'(cpu_ce), 32'd0);
      check("rst2_step_count", step_count, 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      check("rst2_first_cycle_ce", 32'(cpu_ce), 32'd0);
      @(negedge CLK);
      check("rst2_run_ce", 32'(cpu_ce), 32'd1);
      check("rst2_run_halted", 32'(halted), 32'd0);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge CLK);
         if (halted) found = 1'b1;
      end
      check("rst2_halts_again", 32'(found), 32'd1);
      check("rst2_halt_pc", 32'(pc), 32'd5);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/cpu_step_controller.md
Name: cpu_step_controller

Overview:
Parametrised CPU clock-enable and debug-step controller for the pipelined 16-bit CPU. It replaces the divided and gated CPU clocks with a single-clock enable (cpu_ce), so all pipeline registers run on CLK and load only when cpu_ce=1. It supports four modes: free-run, programmable divide, debounced single-step, and run-to-breakpoint with PC match and resume. It also keeps an executed-cycle counter for the VGA debug display.

Parameters:
DIV_W, 8, width of div_ratio
DEBOUNCE_CYCLES, 50000, number of stable cycles required to accept a button level change (>=2)
PC_W, 16, width of pc and bp_addr
CNT_W, 32, width of step_count

Ports:
CLK  in  1  system clock; all state on rising edge
RST  in  1  reset, asynchronous, active-low
mode  in  2  00 free-run, 01 divided, 10 single-step, 11 run-to-breakpoint
div_ratio  in  DIV_W  mode 01: one enable every div_ratio+1 cycles
button  in  1  raw push button, asynchronous, active-low (0 = pressed)
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint address
pc  in  PC_W  current fetch-stage PC
cpu_ce  out  1  pipeline clock enable
halted  out  1  1 while stopped at a breakpoint
btn_pulse  out  1  one-cycle debounced press event
step_count  out  CNT_W  number of cycles with cpu_ce=1

Behaviour:
- Reset (RST=0, asynchronous) sets:
  - ce_req=0, div_cnt=0, step_count=0, state=RUN
  - both synchroniser flops=1, stable=1, deb_cnt=0, btn_pulse=0
  - outputs: cpu_ce=0, halted=0 while RST=0
- Button path:
  - Two-flop synchroniser; the result is compared against the registered `stable`.
  - If sync!=stable, deb_cnt increments; otherwise deb_cnt clears.
  - When deb_cnt reaches DEBOUNCE_CYCLES-1 with the mismatch still present, stable takes sync and deb_cnt clears.
  - Any return to equality before that point clears deb_cnt (glitch rejected).
  - btn_pulse is registered: 1 for exactly one cycle after stable goes 1->0. Release generates nothing.
- ce_req is a register, next value by mode:
  - 00: 1.
  - 01: if div_cnt>=div_ratio, then ce_req=1 and div_cnt=0; else ce_req=0 and div_cnt+1. A reduced div_ratio mid-count takes effect immediately via >=. div_ratio=0 gives an enable every cycle.
  - 10: ce_req = btn_pulse, so cpu_ce follows the press event with exactly 1 cycle latency. Held button gives one pulse only.
  - 11: depends on state (see state machine below).
  - div_cnt clears whenever mode!=01.
- Breakpoint gating:
  - bp_hit = (mode==11) & bp_en & (pc==bp_addr) & (state==RUN), combinational.
  - cpu_ce = ce_req & ~bp_hit. The PC holds at bp_addr and the instruction at bp_addr does not advance.
- Mode-11 state machine:
  - RUN: ce_req next = 1. On bp_hit, go to HALT.
  - HALT: ce_req next = 0; halted=1. On btn_pulse, go to STEP_OVER with ce_req next = 1.
  - STEP_OVER: bp_hit is masked, giving exactly one enable that moves past bp_addr. Then go to RUN.
  - bp_en dropping while in HALT does not release; a button press is required.
  - mode leaving 11 in any state forces RUN at the next edge and halted=0.
- halted is registered: (state==HALT).
- step_count increments on every cycle with cpu_ce=1 and wraps modulo 2^CNT_W.
- Simultaneous events:
  - btn_pulse in the same cycle as the RUN->HALT transition is ignored.
  - A mode write takes effect at the next edge.

Test Plan:
- Mode 00, release RST, run 10 edges -> cpu_ce=0 in the first cycle, then 1 continuously; step_count=9.
- Mode 01, div_ratio=3, 20 cycles after the first pulse -> cpu_ce high every 4th cycle (5 pulses); change to div_ratio=0 -> enable every cycle from the next cycle.
- DEBOUNCE_CYCLES=8: button low for 3 cycles then high -> btn_pulse never asserts; held low 20 cycles -> exactly one btn_pulse; release 20 cycles and press again -> a second pulse.
- Mode 10, two debounced presses -> exactly two single-cycle cpu_ce pulses, each one cycle after btn_pulse; step_count=2.
- Mode 11, bp_en=1, bp_addr=0x0005, bench PC increments on cpu_ce from 0:
  - cpu_ce=0 while pc=0x0005; halted=1 from the next cycle; pc stays at 5 for 100 cycles.
  - Press -> exactly one enable, pc=6, halted=0, free-run resumes.
  - Repeat with bp_en=0 -> no stop.
- Assert RST mid-HALT -> halted, cpu_ce, step_count read 0 immediately without a clock edge; after release the block restarts in RUN.
